// File: rtl/rock_pkg.sv
// rock_pkg: shared definitions for the cradle drive stage.
//   rock_state_t  drive state (IDLE, RUN, HALT)
//   *_DEF         default parameter values for rock_drive / rock_pwm
//   half_len()    length of one half swing in clk cycles for a frequency level
package rock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } rock_state_t;

    localparam int A_W_DEF       = 4;
    localparam int F_W_DEF       = 3;
    localparam int FREQ_MAX_DEF  = 7;
    localparam int HALF_UNIT_DEF = 1000;
    localparam int AMP_INIT_DEF  = 12;

    // Higher frequency level means a shorter half swing; level FREQ_MAX is
    // one unit long and level 1 is FREQ_MAX units long.
    function automatic int unsigned half_len(input int unsigned half_unit,
                                             input int unsigned freq_max,
                                             input int unsigned freq_level);
        return half_unit * (freq_max + 1 - freq_level);
    endfunction

endpackage

// File: rtl/rock_pwm.sv
// rock_pwm: magnitude PWM for the cradle motor.
//   clk    clock
//   reset  asynchronous, active-high
//   en     drive permitted (motor running)
//   level  amplitude level; duty = level / (2^A_W - 1)
//   pwm    registered PWM output
module rock_pwm
    import rock_pkg::*;
#(
    parameter int A_W = A_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [A_W-1:0] level,
    output logic           pwm
);

    // The counter wraps one short of all-ones so that the maximum level
    // compares true on every count and gives a constant high output.
    localparam logic [A_W-1:0] CNT_LAST = A_W'((2 ** A_W) - 2);

    logic [A_W-1:0] pwm_cnt;

    // Free-running PWM period counter, 0 .. AMP_MAX-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == CNT_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Registered comparator; gated off whenever the motor is not running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm <= 1'b0;
        end else begin
            pwm <= en & (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/rock_drive.sv
// rock_drive: cradle motor drive stage behind the rocking path controller.
// Holds amplitude/frequency levels, applies controller decisions on the
// step strobe, produces a swing direction and a PWM magnitude, and latches
// a safe halt on controller error until an operator resume.
//   clk, reset          clock, asynchronous active-high reset
//   step                decision strobe qualifying amin/fplus/fmin/error
//   amin                decrease amplitude
//   fplus, fmin         increase / decrease frequency
//   error               controller fault (enters HALT)
//   enable              permits motion
//   resume              leaves HALT
//   motor_dir           swing direction, toggles every half swing
//   motor_pwm           drive magnitude PWM
//   amp_level           current amplitude level
//   freq_level          current frequency level
//   running, halted     state == RUN, state == HALT
module rock_drive
    import rock_pkg::*;
#(
    parameter int A_W       = A_W_DEF,
    parameter int F_W       = F_W_DEF,
    parameter int FREQ_MAX  = FREQ_MAX_DEF,
    parameter int HALF_UNIT = HALF_UNIT_DEF,
    parameter int AMP_INIT  = AMP_INIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           step,
    input  logic           amin,
    input  logic           fplus,
    input  logic           fmin,
    input  logic           error,
    input  logic           enable,
    input  logic           resume,
    output logic           motor_dir,
    output logic           motor_pwm,
    output logic [A_W-1:0] amp_level,
    output logic [F_W-1:0] freq_level,
    output logic           running,
    output logic           halted
);

    localparam int             HC_W     = $clog2(HALF_UNIT * FREQ_MAX + 1);
    localparam logic [F_W-1:0] FREQ_TOP = F_W'(FREQ_MAX);
    localparam logic [F_W-1:0] FREQ_ONE = F_W'(1);
    localparam logic [A_W-1:0] AMP_RST  = A_W'(AMP_INIT);

    rock_state_t     state;
    logic [HC_W-1:0] half_cnt;
    logic [HC_W-1:0] half_reload;
    logic            halt_req;

    assign halt_req = step & error;

    // Reload value always uses the registered frequency level, so a level
    // change on the same edge only affects the following half swing.
    assign half_reload = HC_W'(half_len(HALF_UNIT, FREQ_MAX, 32'(freq_level)) - 32'd1);

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALT);

    // Drive FSM with the half-swing counter and direction register. The
    // counter only advances on edges where the drive stays in RUN; any exit
    // freezes it, and re-entering RUN starts a fresh half swing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            half_cnt  <= '0;
            motor_dir <= 1'b0;
        end else if (halt_req) begin
            state <= ST_HALT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && (amp_level != '0)) begin
                        state    <= ST_RUN;
                        half_cnt <= half_reload;
                    end
                end
                ST_RUN: begin
                    if (!enable || (amp_level == '0)) begin
                        state <= ST_IDLE;
                    end else if (half_cnt == '0) begin
                        motor_dir <= ~motor_dir;
                        half_cnt  <= half_reload;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Amplitude and frequency levels. Decisions are frozen while halted;
    // leaving HALT restores the safe starting levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            amp_level  <= AMP_RST;
            freq_level <= FREQ_ONE;
        end else if (state == ST_HALT) begin
            if (resume && !halt_req) begin
                amp_level  <= AMP_RST;
                freq_level <= FREQ_ONE;
            end
        end else if (step && !error) begin
            if (amin && (amp_level != '0)) begin
                amp_level <= amp_level - 1'b1;
            end
            if (fplus && !fmin && (freq_level != FREQ_TOP)) begin
                freq_level <= freq_level + 1'b1;
            end else if (fmin && !fplus && (freq_level > FREQ_ONE)) begin
                freq_level <= freq_level - 1'b1;
            end
        end
    end

    rock_pwm #(
        .A_W (A_W)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .en    (running),
        .level (amp_level),
        .pwm   (motor_pwm)
    );

endmodule

// File: tb/tb_rock_drive.sv
// tb_rock_drive: directed scoreboard bench for rock_drive
// (HALF_UNIT=4, FREQ_MAX=7, A_W=4, AMP_INIT=12).
// Stimulus pushes expected observations tagged with the cycle at which they
// must hold; a monitor sampling on the falling edge pops and compares them,
// and separately matches every motor_dir toggle against expected toggle cycles.
module tb_rock_drive;

    localparam int S_DIR   = 0;
    localparam int S_PWM   = 1;
    localparam int S_AMP   = 2;
    localparam int S_FREQ  = 3;
    localparam int S_RUN   = 4;
    localparam int S_HALT  = 5;
    localparam int S_PWM15 = 6;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } chk_t;

    logic       clk;
    logic       reset;
    logic       step, amin, fplus, fmin, error, enable, resume;
    logic       motor_dir, motor_pwm, running, halted;
    logic [3:0] amp_level;
    logic [2:0] freq_level;

    chk_t        check_q[$];
    int          dir_q[$];
    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] pwm_hist = '0;
    logic        prev_dir = 1'b0;
    int          c0, c1, c3, c4, c5, c6, c7, c8;

    rock_drive #(
        .A_W       (4),
        .F_W       (3),
        .FREQ_MAX  (7),
        .HALF_UNIT (4),
        .AMP_INIT  (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .amin       (amin),
        .fplus      (fplus),
        .fmin       (fmin),
        .error      (error),
        .enable     (enable),
        .resume     (resume),
        .motor_dir  (motor_dir),
        .motor_pwm  (motor_pwm),
        .amp_level  (amp_level),
        .freq_level (freq_level),
        .running    (running),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExpect(input string name, input int sig, input int val, input int at);
        chk_t c;
        int   i;
        c.cyc  = at;
        c.sig  = sig;
        c.val  = val;
        c.name = name;
        i = 0;
        while (i < check_q.size() && check_q[i].cyc <= at) i++;
        check_q.insert(i, c);
    endtask

    task automatic pushDir(input int at);
        dir_q.push_back(at);
    endtask

    task automatic checkOutput(input chk_t c);
        int act;
        case (c.sig)
            S_DIR:   act = int'(motor_dir);
            S_PWM:   act = int'(motor_pwm);
            S_AMP:   act = int'(amp_level);
            S_FREQ:  act = int'(freq_level);
            S_RUN:   act = int'(running);
            S_HALT:  act = int'(halted);
            S_PWM15: act = $countones(pwm_hist[14:0]);
            default: act = -1;
        endcase
        checks++;
        if (act != c.val) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", c.name, cyc, act, c.val);
        end
    endtask

    task automatic applyStimulus(input logic s_step, input logic s_amin, input logic s_fplus,
                                 input logic s_fmin, input logic s_error, input logic s_resume);
        step   = s_step;
        amin   = s_amin;
        fplus  = s_fplus;
        fmin   = s_fmin;
        error  = s_error;
        resume = s_resume;
        @(negedge clk);
        step   = 1'b0;
        amin   = 1'b0;
        fplus  = 1'b0;
        fmin   = 1'b0;
        error  = 1'b0;
        resume = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pushResetValues(input string tag, input int at);
        pushExpect({tag, "_dir"},     S_DIR,  0,  at);
        pushExpect({tag, "_pwm"},     S_PWM,  0,  at);
        pushExpect({tag, "_running"}, S_RUN,  0,  at);
        pushExpect({tag, "_halted"},  S_HALT, 0,  at);
        pushExpect({tag, "_amp"},     S_AMP,  12, at);
        pushExpect({tag, "_freq"},    S_FREQ, 1,  at);
    endtask

    // Monitor: scoreboard checks plus direction-toggle matching.
    initial begin
        chk_t c;
        int   exp_cyc;
        forever begin
            @(negedge clk);
            pwm_hist = {pwm_hist[62:0], motor_pwm};
            while (check_q.size() > 0 && check_q[0].cyc <= cyc) begin
                c = check_q.pop_front();
                if (c.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL %s: got no sample at cycle %0d expected one", c.name, c.cyc);
                end else begin
                    checkOutput(c);
                end
            end
            if (reset) begin
                prev_dir = motor_dir;
            end else begin
                while (dir_q.size() > 0 && dir_q[0] < cyc) begin
                    exp_cyc = dir_q.pop_front();
                    checks++;
                    failures++;
                    $display("[TB] FAIL dir_toggle: got no toggle by cycle %0d expected toggle at %0d", cyc, exp_cyc);
                end
                if (motor_dir !== prev_dir) begin
                    checks++;
                    if (dir_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL dir_toggle: got toggle at cycle %0d expected none", cyc);
                    end else begin
                        exp_cyc = dir_q.pop_front();
                        if (exp_cyc != cyc) begin
                            failures++;
                            $display("[TB] FAIL dir_toggle: got toggle at cycle %0d expected at %0d", cyc, exp_cyc);
                        end
                    end
                end
                prev_dir = motor_dir;
            end
        end
    end

    initial begin
        reset  = 1'b1;
        step   = 1'b0;
        amin   = 1'b0;
        fplus  = 1'b0;
        fmin   = 1'b0;
        error  = 1'b0;
        enable = 1'b0;
        resume = 1'b0;

        // Reset values, then idle with enable low.
        @(negedge clk);
        pushResetValues("reset", 2);
        waitUntil(3);
        reset = 1'b0;
        pushExpect("idle_no_enable", S_RUN, 0, 5);

        // Scenario 1: enable -> RUN, 28-cycle half swing, 12/15 duty.
        waitUntil(5);
        c0 = cyc;
        pushExpect("run_entry",   S_RUN,   1,  c0 + 1);
        pushExpect("amp_init",    S_AMP,   12, c0 + 1);
        pushExpect("freq_init",   S_FREQ,  1,  c0 + 1);
        pushExpect("pwm_duty_a",  S_PWM15, 12, c0 + 16);
        pushExpect("pwm_duty_b",  S_PWM15, 12, c0 + 45);
        pushDir(c0 + 29);
        pushDir(c0 + 57);
        enable = 1'b1;

        // Scenario 2: seven fplus steps; current half swing finishes at 28.
        waitUntil(c0 + 60);
        c1 = cyc;
        pushExpect("freq_ramp",  S_FREQ, 4, c1 + 3);
        pushExpect("freq_sat",   S_FREQ, 7, c1 + 8);
        pushDir(c1 + 25);
        pushDir(c1 + 29);
        pushDir(c1 + 33);
        pushDir(c1 + 37);
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 1, 0, 0, 0);

        // fmin then fplus+fmin: level 6 holds; boundary toggle uses old level.
        waitUntil(c1 + 40);
        c3 = cyc;
        pushExpect("freq_both_hold", S_FREQ, 6, c3 + 3);
        pushDir(c3 + 1);
        pushDir(c3 + 5);
        pushDir(c3 + 13);
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);

        // Enable low for 10 cycles mid swing; swing restarts from full length.
        waitUntil(c3 + 16);
        c4 = cyc;
        pushExpect("en_low_idle",  S_RUN, 0, c4 + 1);
        pushExpect("en_low_pwm",   S_PWM, 0, c4 + 3);
        pushExpect("en_high_run",  S_RUN, 1, c4 + 12);
        pushDir(c4 + 19);
        pushDir(c4 + 27);
        enable = 1'b0;
        waitUntil(c4 + 10);
        enable = 1'b1;

        // Scenario 4: step+error+fplus in RUN, then step+fmin while halted.
        waitUntil(c4 + 30);
        c5 = cyc;
        pushExpect("err_halted",     S_HALT, 1,  c5 + 1);
        pushExpect("err_not_run",    S_RUN,  0,  c5 + 1);
        pushExpect("err_freq_keep",  S_FREQ, 6,  c5 + 1);
        pushExpect("err_pwm_off",    S_PWM,  0,  c5 + 3);
        pushExpect("halt_step_freq", S_FREQ, 6,  c5 + 6);
        pushExpect("halt_step_amp",  S_AMP,  12, c5 + 6);
        pushExpect("halt_stays",     S_HALT, 1,  c5 + 6);
        applyStimulus(1, 0, 1, 0, 1, 0);
        waitUntil(c5 + 4);
        applyStimulus(1, 0, 0, 1, 0, 0);

        // Scenario 5: resume with step+error stays halted; resume alone exits.
        waitUntil(c5 + 8);
        c6 = cyc;
        pushExpect("resume_err_halt", S_HALT, 1, c6 + 2);
        pushExpect("resume_err_freq", S_FREQ, 6, c6 + 2);
        applyStimulus(1, 0, 0, 0, 1, 1);
        waitUntil(c6 + 3);
        pushExpect("resume_unhalt",  S_HALT, 0,  c6 + 4);
        pushExpect("resume_idle",    S_RUN,  0,  c6 + 4);
        pushExpect("resume_amp",     S_AMP,  12, c6 + 4);
        pushExpect("resume_freq",    S_FREQ, 1,  c6 + 4);
        pushExpect("resume_run",     S_RUN,  1,  c6 + 5);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Move levels off their reset values, then reset mid swing.
        waitUntil(c6 + 10);
        pushExpect("pre_reset_freq", S_FREQ, 2, c6 + 12);
        applyStimulus(1, 0, 1, 0, 0, 0);
        pushExpect("pre_reset_amp", S_AMP, 11, c6 + 13);
        applyStimulus(1, 1, 0, 0, 0, 0);
        c7 = c6 + 20;
        waitUntil(c7 - 2);
        pushExpect("pre_reset_dir", S_DIR, 1, c7 - 1);
        pushExpect("pre_reset_run", S_RUN, 1, c7 - 1);
        waitUntil(c7 - 1);
        pushResetValues("async_reset", c7);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        pushExpect("reset_held_idle", S_RUN, 0, c7 + 1);
        waitUntil(c7 + 2);
        pushExpect("post_reset_run", S_RUN, 1, c7 + 3);
        reset = 1'b0;

        // Scenario 3: fourteen amin steps -> amp 0, IDLE, pwm 0, dir frozen.
        waitUntil(c7 + 5);
        c8 = cyc;
        pushExpect("amin_mid",       S_AMP,   7, c8 + 5);
        pushExpect("amin_still_run", S_RUN,   1, c8 + 12);
        pushExpect("amin_zero",      S_AMP,   0, c8 + 13);
        pushExpect("amin_idle",      S_RUN,   0, c8 + 13);
        pushExpect("amin_pwm_off",   S_PWM,   0, c8 + 15);
        pushExpect("amin_pwm_quiet", S_PWM15, 0, c8 + 30);
        pushExpect("amin_zero_hold", S_AMP,   0, c8 + 31);
        pushExpect("amin_freq",      S_FREQ,  1, c8 + 31);
        for (int i = 0; i < 14; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        waitUntil(c8 + 40);

        checks++;
        if (check_q.size() + dir_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL leftover: got %0d pending expectations expected 0",
                     check_q.size() + dir_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rock_drive.md
# rock_drive

Motor drive stage directly downstream of the rocking path controller. It consumes the controller's amplitude-decrease, frequency-up/down and error indications and turns them into a cradle swing: a direction signal toggling every half swing, plus a PWM magnitude. It holds the current amplitude and frequency levels, applies controller decisions only on a decision strobe, and latches a safe halt on error until an operator resume.

## Interface
- `A_W`, default 4: amplitude level width. `AMP_MAX` = 2^A_W−1.
- `F_W`, default 3: frequency level width.
- `FREQ_MAX`, default 7: highest frequency level; must be ≤ 2^F_W−1.
- `HALF_UNIT`, default 1000: clk cycles per half-swing unit.
- `AMP_INIT`, default 12: amplitude level after reset and after resume; must be 1..AMP_MAX.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `step`  in  1  one-cycle decision strobe; `amin`/`fplus`/`fmin`/`error` are sampled only when it is high.
- `amin`  in  1  decrease amplitude.
- `fplus`  in  1  increase frequency.
- `fmin`  in  1  decrease frequency.
- `error`  in  1  controller fault.
- `enable`  in  1  level; permits motion.
- `resume`  in  1  one-cycle pulse; leaves HALT.
- `motor_dir`  out  1  swing direction.
- `motor_pwm`  out  1  drive magnitude PWM.
- `amp_level`  out  A_W  current amplitude level.
- `freq_level`  out  F_W  current frequency level.
- `running`  out  1  state == RUN.
- `halted`  out  1  state == HALT.

## Operation
- **States:** IDLE, RUN, HALT. Reset state is IDLE.
- **IDLE→RUN** when `enable` is high and `amp_level` ≠ 0. On entry, load the half counter and keep `motor_dir` unchanged.
- **RUN→IDLE** when `enable` is low or `amp_level` = 0. The half counter freezes.
- **Any state→HALT** on an edge where `step & error`.
  - `error` has priority: the adjust bits in that step are ignored.
- **HALT→IDLE** on `resume`, provided `step & error` is not also true in the same cycle; if both, stay in HALT.
  - On leaving HALT, reload `amp_level` = AMP_INIT and `freq_level` = 1.
- **In HALT:** `step` has no effect on the levels.
- **Level updates** happen on a `step` edge without `error`, in any state other than HALT:
  - `amin`: `amp_level` decrements, saturating at 0.
  - `fplus & ~fmin`: `freq_level` increments, saturating at FREQ_MAX.
  - `fmin & ~fplus`: `freq_level` decrements, saturating at 1.
  - `fplus & fmin`: `freq_level` holds.
- **Half swing:**
  - Length `half_len` = HALF_UNIT × (FREQ_MAX+1−freq_level) cycles.
  - Compute it at width ⌈log2(HALF_UNIT×FREQ_MAX+1)⌉.
  - The counter loads `half_len`−1 and counts down in RUN.
  - At 0: toggle `motor_dir` and reload, using the `freq_level` current at that edge.
  - A frequency change therefore takes effect at the next boundary and never truncates the half swing in progress.
- **PWM:**
  - A free-running counter `pwm_cnt` cycles 0..AMP_MAX−1.
  - `motor_pwm` is registered as (state == RUN) & (`pwm_cnt` < `amp_level`).
  - `amp_level` = AMP_MAX gives a constant 1; `amp_level` = 0 gives a constant 0.

## Timing
- **Reset values:**
  - `motor_dir` = 0, `motor_pwm` = 0, `running` = 0, `halted` = 0.
  - `amp_level` = AMP_INIT, `freq_level` = 1.
  - Half counter = 0, `pwm_cnt` = 0.
- **Level and state latency:** level and state changes are visible the cycle after the sampling edge.
- **PWM latency:** `motor_pwm` lags the state by one further cycle. It is low no later than 2 edges after the edge that leaves RUN.
- **Direction period:** `motor_dir` toggles exactly every `half_len` cycles while in RUN; time spent in IDLE is not counted.
- **Reset mid-swing:** all outputs return to their reset values immediately (asynchronous).

## Structure
- Package `rock_pkg`:
  - state enum (IDLE, RUN, HALT);
  - parameter defaults;
  - a `half_len` function.
- One sub-module, `rock_pwm`:
  - contains the PWM counter and comparator;
  - inputs: `clk`, `reset`, `en`, `level[A_W]`; output `pwm`.
- The top-level module contains the FSM, level registers and the half counter.

## Test plan
All scenarios use the bench parameters HALF_UNIT=4, FREQ_MAX=7, A_W=4, AMP_INIT=12.
1. Reset, `enable`=1 → RUN; `motor_dir` toggles every 28 cycles; `motor_pwm` is high 12 of every 15 cycles.
2. Seven `step`+`fplus` pulses → `freq_level` saturates at 7. The half swing in progress completes at its old length, then `motor_dir` toggles every 4 cycles.
3. Fourteen `step`+`amin` pulses → `amp_level` saturates at 0, state goes to IDLE, `motor_pwm` = 0, and `motor_dir` freezes.
4. `step`+`error`+`fplus` in RUN:
   - `halted`=1 on the next cycle and `freq_level` unchanged;
   - `motor_pwm` = 0 within 2 edges;
   - `step`+`fmin` while halted → no change.
5. In HALT, `resume` together with `step`+`error` → stays in HALT. Then `resume` alone → IDLE with `amp_level`=12 and `freq_level`=1, then RUN because `enable` is high.
6. Miscellaneous boundary cases:
   - `step`+`fplus`+`fmin` → `freq_level` holds;
   - `enable` low for 10 cycles in mid swing → the half swing resumes from a freshly loaded counter;
   - `reset` pulsed mid-swing → all outputs return to reset values immediately.
